uart_boot_loader: RTL and testbench
===================================

Name: uart_boot_loader

Overview:
Serial program loader upstream of the CPU top level and its test memory. Receives a framed byte stream on a UART RX pin and emits one memory write per payload byte into the 16-bit address space. Holds the CPU in reset until the load completes, then releases it. Protocol: addr_lo, addr_hi, len_lo, len_hi, then len payload bytes.

Parameters:
CLKS_PER_BIT, 104, clock cycles per UART bit (12 MHz / 115200); legal range 4..65535.

Ports:
clk  input  1  system clock
rst  input  1  asynchronous active-high reset
rx  input  1  UART receive line, idle high, 8N1, LSB first
ld_addr_l  output  8  write address low byte (to memory_bus_l side)
ld_addr_h  output  8  write address high byte (to memory_bus_h side)
ld_data  output  8  write data
ld_we  output  1  one-cycle write strobe; address/data valid while high
cpu_hold  output  1  high = CPU held in reset
done  output  1  sticky, load complete
frame_err  output  1  sticky, a stop bit was sampled low

Behaviour:
- Reset is asynchronous and active-high. It forces all state immediately and is released synchronously to clk.
- Reset values: ld_addr_l=0, ld_addr_h=0, ld_data=0, ld_we=0, cpu_hold=1, done=0, frame_err=0, RX FSM=IDLE, loader FSM=ADDR_L.
- rx passes through a 2-flop synchronizer (reset value 1) before any use. All timing below is relative to the synchronized rx.
- RX FSM:
  - IDLE: on a 1->0 transition of the synchronized rx, go to START and clear the bit counter.
  - START: wait CLKS_PER_BIT/2 cycles (integer divide). If rx is still 0, go to DATA. Otherwise treat it as a glitch and return to IDLE.
  - DATA: sample every CLKS_PER_BIT cycles, 8 samples, shifting in LSB first, then go to STOP.
  - STOP: sample after CLKS_PER_BIT cycles.
    - rx=1: the byte is valid; pulse the internal byte_valid for 1 cycle and go to IDLE.
    - rx=0: set frame_err, discard the byte, go to IDLE. Re-arming requires rx to return to 1 first.
- Loader FSM advances only on byte_valid:
  - ADDR_L: capture the byte into the address low byte.
  - ADDR_H: capture the byte into the address high byte.
  - LEN_L: capture into the 16-bit remaining counter, low byte.
  - LEN_H: capture into the remaining counter, high byte. If the full 16-bit length is 0, go directly to DONE; otherwise go to DATA.
  - DATA: drive ld_data=byte and ld_addr={h,l} = current address, with ld_we=1 for exactly one cycle. Latency: ld_we asserts in the cycle after byte_valid. The address increments and remaining decrements in the cycle after ld_we, so outputs are stable during the strobe. The 16-bit address wraps 0xFFFF->0x0000; the carry from addr_l propagates into addr_h. When remaining reaches 0, go to DONE.
  - DONE: set done=1 and drop cpu_hold to 0 in the same cycle, no earlier than the cycle after the last ld_we. Every later byte is ignored and ld_we never asserts again until reset.
- ld_addr_l, ld_addr_h and ld_data hold their last values when ld_we=0.
- frame_err does not abort the load; the discarded byte simply does not advance the loader.
- Reset mid-byte or mid-load: everything returns to reset values immediately and cpu_hold goes to 1. A partially received byte is lost. The next start bit begins a new header at ADDR_L.
- A new start edge is accepted starting the cycle the RX FSM enters IDLE, so back-to-back frames with zero idle time are received.

Test Plan:
- Reset -> ld_we=0, cpu_hold=1, done=0, frame_err=0, all addr/data outputs 0x00; rx held high for 1000 cycles produces no ld_we.
- CLKS_PER_BIT=4, send 00 02 03 00 A9 42 8D -> three ld_we pulses at 0x0200/A9, 0x0201/42, 0x0202/8D; then done=1 and cpu_hold=0 one cycle after the third pulse.
- Send FE FF 03 00 11 22 33 -> writes to 0xFFFE, 0xFFFF, 0x0000, confirming the address wrap.
- Send 00 10 00 00 -> no ld_we; done=1 and cpu_hold=0 after the fourth byte; following bytes produce no writes.
- Header 00 03 02 00, then a frame with stop bit 0, then 55 66 -> frame_err=1; writes are 0x0300/55 and 0x0301/66; done=1.
- A 1-cycle low glitch on rx -> no byte accepted. Assert rst mid-payload of a 5-byte load -> outputs return to reset values at once; a fresh header plus payload completes normally.

Source files
------------

// File: rtl/uart_boot_loader.sv
// UART-fed program loader: parses an addr/len header, streams payload bytes out as
// single-cycle memory writes, and holds the CPU in reset until the load is finished.
module uart_boot_loader #(
    parameter int CLKS_PER_BIT = 104
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    output logic [7:0] ld_addr_l,
    output logic [7:0] ld_addr_h,
    output logic [7:0] ld_data,
    output logic       ld_we,
    output logic       cpu_hold,
    output logic       done,
    output logic       frame_err
);

    localparam logic [15:0] BIT_LAST  = 16'(CLKS_PER_BIT - 1);
    localparam logic [15:0] HALF_LAST = 16'((CLKS_PER_BIT / 2) - 1);

    typedef enum logic [1:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_STOP
    } rxState_t;

    typedef enum logic [2:0] {
        LD_ADDR_L,
        LD_ADDR_H,
        LD_LEN_L,
        LD_LEN_H,
        LD_DATA,
        LD_DONE
    } ldState_t;

    logic        rxMeta_q;
    logic        rxSync_q;
    logic        rxPrev_q;

    rxState_t    rxState_q;
    logic [15:0] bitCnt_q;
    logic [2:0]  bitIdx_q;
    logic [7:0]  shift_q;
    logic        byteValid_q;
    logic        frameErr_q;

    ldState_t    ldState_q;
    logic [15:0] addr_q;
    logic [15:0] remain_q;
    logic [7:0]  ldAddrL_q;
    logic [7:0]  ldAddrH_q;
    logic [7:0]  ldData_q;
    logic        ldWe_q;
    logic        cpuHold_q;
    logic        done_q;

    logic [15:0] addrInc_d;
    logic [15:0] remainDec_d;
    logic [15:0] lenFull_d;

    // rxPrev_q tracks the synchronized line so a start edge needs a real 1->0 transition.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rxMeta_q <= 1'b1;
            rxSync_q <= 1'b1;
            rxPrev_q <= 1'b1;
        end else begin
            rxMeta_q <= rx;
            rxSync_q <= rxMeta_q;
            rxPrev_q <= rxSync_q;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rxState_q   <= RX_IDLE;
            bitCnt_q    <= '0;
            bitIdx_q    <= '0;
            shift_q     <= '0;
            byteValid_q <= 1'b0;
            frameErr_q  <= 1'b0;
        end else begin
            byteValid_q <= 1'b0;
            case (rxState_q)
                RX_IDLE: begin
                    if (rxPrev_q && !rxSync_q) begin
                        rxState_q <= RX_START;
                        bitCnt_q  <= '0;
                        bitIdx_q  <= '0;
                    end
                end
                RX_START: begin
                    if (bitCnt_q == HALF_LAST) begin
                        bitCnt_q  <= '0;
                        rxState_q <= rxSync_q ? RX_IDLE : RX_DATA;
                    end else begin
                        bitCnt_q <= bitCnt_q + 16'd1;
                    end
                end
                RX_DATA: begin
                    if (bitCnt_q == BIT_LAST) begin
                        bitCnt_q <= '0;
                        shift_q  <= {rxSync_q, shift_q[7:1]};
                        bitIdx_q <= bitIdx_q + 3'd1;
                        if (bitIdx_q == 3'd7) begin
                            rxState_q <= RX_STOP;
                        end
                    end else begin
                        bitCnt_q <= bitCnt_q + 16'd1;
                    end
                end
                RX_STOP: begin
                    if (bitCnt_q == BIT_LAST) begin
                        bitCnt_q  <= '0;
                        rxState_q <= RX_IDLE;
                        if (rxSync_q) begin
                            byteValid_q <= 1'b1;
                        end else begin
                            frameErr_q <= 1'b1;
                        end
                    end else begin
                        bitCnt_q <= bitCnt_q + 16'd1;
                    end
                end
                default: rxState_q <= RX_IDLE;
            endcase
        end
    end

    always_comb begin
        addrInc_d   = addr_q + 16'd1;
        remainDec_d = remain_q - 16'd1;
        lenFull_d   = {shift_q, remain_q[7:0]};
    end

    // The address/count update is deferred to the strobe cycle so outputs stay stable while ld_we is high.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ldState_q <= LD_ADDR_L;
            addr_q    <= '0;
            remain_q  <= '0;
            ldAddrL_q <= '0;
            ldAddrH_q <= '0;
            ldData_q  <= '0;
            ldWe_q    <= 1'b0;
            cpuHold_q <= 1'b1;
            done_q    <= 1'b0;
        end else begin
            ldWe_q <= 1'b0;
            case (ldState_q)
                LD_ADDR_L: begin
                    if (byteValid_q) begin
                        addr_q[7:0] <= shift_q;
                        ldState_q   <= LD_ADDR_H;
                    end
                end
                LD_ADDR_H: begin
                    if (byteValid_q) begin
                        addr_q[15:8] <= shift_q;
                        ldState_q    <= LD_LEN_L;
                    end
                end
                LD_LEN_L: begin
                    if (byteValid_q) begin
                        remain_q[7:0] <= shift_q;
                        ldState_q     <= LD_LEN_H;
                    end
                end
                LD_LEN_H: begin
                    if (byteValid_q) begin
                        remain_q <= lenFull_d;
                        if (lenFull_d == 16'd0) begin
                            ldState_q <= LD_DONE;
                            done_q    <= 1'b1;
                            cpuHold_q <= 1'b0;
                        end else begin
                            ldState_q <= LD_DATA;
                        end
                    end
                end
                LD_DATA: begin
                    if (ldWe_q) begin
                        addr_q   <= addrInc_d;
                        remain_q <= remainDec_d;
                        if (remain_q == 16'd1) begin
                            ldState_q <= LD_DONE;
                            done_q    <= 1'b1;
                            cpuHold_q <= 1'b0;
                        end
                    end else if (byteValid_q) begin
                        ldWe_q    <= 1'b1;
                        ldData_q  <= shift_q;
                        ldAddrL_q <= addr_q[7:0];
                        ldAddrH_q <= addr_q[15:8];
                    end
                end
                LD_DONE: begin
                    done_q    <= 1'b1;
                    cpuHold_q <= 1'b0;
                end
                default: ldState_q <= LD_ADDR_L;
            endcase
        end
    end

    assign ld_addr_l = ldAddrL_q;
    assign ld_addr_h = ldAddrH_q;
    assign ld_data   = ldData_q;
    assign ld_we     = ldWe_q;
    assign cpu_hold  = cpuHold_q;
    assign done      = done_q;
    assign frame_err = frameErr_q;

endmodule

// File: tb/tb_uart_boot_loader.sv
// Scoreboard bench for uart_boot_loader: a protocol-level model predicts every memory
// write, and a monitor compares each ld_we strobe against the expected queue.
`timescale 1ns/1ps
module tb_uart_boot_loader;

    localparam int CLKS = 4;

    typedef struct packed {
        logic [15:0] addr;
        logic [7:0]  data;
        logic        last;
    } wr_t;

    logic       clk;
    logic       rst;
    logic       rx;
    logic [7:0] ld_addr_l;
    logic [7:0] ld_addr_h;
    logic [7:0] ld_data;
    logic       ld_we;
    logic       cpu_hold;
    logic       done;
    logic       frame_err;

    int   checks;
    int   errors;
    wr_t  expQ[$];
    logic [7:0] bq[$];
    bit   donePending;

    int          mIdx;
    logic [15:0] mAddr;
    logic [15:0] mRem;
    bit          mDone;
    bit          mFrameErr;

    uart_boot_loader #(.CLKS_PER_BIT(CLKS)) dut (
        .clk       (clk),
        .rst       (rst),
        .rx        (rx),
        .ld_addr_l (ld_addr_l),
        .ld_addr_h (ld_addr_h),
        .ld_data   (ld_data),
        .ld_we     (ld_we),
        .cpu_hold  (cpu_hold),
        .done      (done),
        .frame_err (frame_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Header is four bytes (addr lo/hi, len lo/hi); after that each byte is one write until len runs out.
    task automatic modelByte(input logic [7:0] b);
        case (mIdx)
            0: begin mAddr[7:0] = b; mIdx = 1; end
            1: begin mAddr[15:8] = b; mIdx = 2; end
            2: begin mRem[7:0] = b; mIdx = 3; end
            3: begin
                mRem[15:8] = b;
                if (mRem == 16'd0) begin mIdx = 5; mDone = 1; end
                else mIdx = 4;
            end
            4: begin
                expQ.push_back('{addr: mAddr, data: b, last: (mRem == 16'd1)});
                mAddr = mAddr + 16'd1;
                mRem  = mRem - 16'd1;
                if (mRem == 16'd0) begin mIdx = 5; mDone = 1; end
            end
            default: ;
        endcase
    endtask

    task automatic sendFrame(input logic [7:0] b, input logic stopBit);
        rx = 1'b0;
        repeat (CLKS) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            repeat (CLKS) @(negedge clk);
        end
        rx = stopBit;
        repeat (CLKS) @(negedge clk);
        rx = 1'b1;
    endtask

    task automatic applyStimulus(input logic [7:0] b, input int gap);
        modelByte(b);
        sendFrame(b, 1'b1);
        repeat (gap) @(negedge clk);
    endtask

    task automatic sendQueue();
        foreach (bq[i]) applyStimulus(bq[i], $urandom_range(0, 6));
    endtask

    task automatic resetDut();
        @(negedge clk);
        #2;
        rst = 1'b1;
        rx  = 1'b1;
        #1;
        checkOutput("rstAddrL", 16'(ld_addr_l), 16'h0);
        checkOutput("rstAddrH", 16'(ld_addr_h), 16'h0);
        checkOutput("rstData", 16'(ld_data), 16'h0);
        checkOutput("rstWe", 16'(ld_we), 16'h0);
        checkOutput("rstHold", 16'(cpu_hold), 16'h1);
        checkOutput("rstDone", 16'(done), 16'h0);
        checkOutput("rstFrameErr", 16'(frame_err), 16'h0);
        expQ.delete();
        mIdx = 0; mAddr = '0; mRem = '0; mDone = 0; mFrameErr = 0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic endCheck();
        repeat (40) @(negedge clk);
        checkOutput("endDone", 16'(done), 16'(mDone));
        checkOutput("endHold", 16'(cpu_hold), 16'(!mDone));
        checkOutput("endFrameErr", 16'(frame_err), 16'(mFrameErr));
        checkOutput("endPending", 16'(expQ.size()), 16'h0);
    endtask

    // Every strobe must match the head of the expected queue; the last write must be followed by done.
    always @(negedge clk) begin
        wr_t e;
        if (rst) begin
            donePending = 0;
        end else begin
            if (donePending) begin
                checkOutput("doneAfterLast", 16'(done), 16'h1);
                checkOutput("holdAfterLast", 16'(cpu_hold), 16'h0);
                donePending = 0;
            end
            if (ld_we) begin
                if (expQ.size() == 0) begin
                    checks++;
                    errors++;
                    $display("[TB] FAIL unexpectedWrite: got write 0x%0h/0x%0h, expected none",
                             {ld_addr_h, ld_addr_l}, ld_data);
                end else begin
                    e = expQ.pop_front();
                    checkOutput("wrAddr", {ld_addr_h, ld_addr_l}, e.addr);
                    checkOutput("wrData", 16'(ld_data), 16'(e.data));
                    checkOutput("doneDuringWe", 16'(done), 16'h0);
                    if (e.last) donePending = 1;
                end
            end
        end
    end

    initial begin
        logic [15:0] rAddr;
        int          rLen;
        checks = 0;
        errors = 0;
        donePending = 0;
        rst = 1'b1;
        rx  = 1'b1;
        mIdx = 0; mAddr = '0; mRem = '0; mDone = 0; mFrameErr = 0;

        resetDut();
        repeat (1000) @(negedge clk);
        endCheck();

        bq = '{8'h00, 8'h02, 8'h03, 8'h00, 8'hA9, 8'h42, 8'h8D};
        sendQueue();
        endCheck();

        resetDut();
        bq = '{8'hFE, 8'hFF, 8'h03, 8'h00, 8'h11, 8'h22, 8'h33};
        sendQueue();
        endCheck();

        resetDut();
        bq = '{8'h00, 8'h10, 8'h00, 8'h00};
        sendQueue();
        endCheck();
        bq = '{8'hAB, 8'hCD};
        sendQueue();
        endCheck();

        resetDut();
        bq = '{8'h00, 8'h03, 8'h02, 8'h00};
        sendQueue();
        mFrameErr = 1;
        sendFrame(8'h77, 1'b0);
        repeat (2 * CLKS) @(negedge clk);
        bq = '{8'h55, 8'h66};
        sendQueue();
        endCheck();

        resetDut();
        bq = '{8'h34, 8'h12, 8'h02, 8'h00};
        sendQueue();
        rx = 1'b0;
        @(negedge clk);
        rx = 1'b1;
        repeat (20) @(negedge clk);
        bq = '{8'h5A, 8'hA5};
        sendQueue();
        endCheck();

        resetDut();
        bq = '{8'h00, 8'h40, 8'h05, 8'h00, 8'h01, 8'h02};
        sendQueue();
        repeat (10) @(negedge clk);
        rx = 1'b0;
        repeat (CLKS) @(negedge clk);
        rx = 1'b1;
        repeat (2 * CLKS) @(negedge clk);
        resetDut();
        bq = '{8'h10, 8'h00, 8'h02, 8'h00, 8'hC3, 8'h3C};
        sendQueue();
        endCheck();

        for (int k = 0; k < 4; k++) begin
            resetDut();
            rLen  = $urandom_range(1, 6);
            rAddr = (k == 0) ? 16'hFFFD : 16'($urandom);
            bq = '{rAddr[7:0], rAddr[15:8], 8'(rLen), 8'h00};
            for (int j = 0; j < rLen; j++) bq.push_back(8'($urandom));
            sendQueue();
            endCheck();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
